direction_ctrl: RTL and testbench

Upstream control stage for the 4-bit up/down counter. It turns a raw, bouncy push-button input into the counter's direction signal `chnge`. The button is synchronised and debounced, and each confirmed press toggles `chnge`. `chnge` connects directly to the counter's `chnge` input and shares its clock and reset.

---
 rtl/direction_ctrl.sv | 117 +++++++++++
 tb/tb_direction_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/direction_ctrl.sv
// Button-to-direction control: synchronises and debounces btn_in, toggles chnge per press.
// Optional long-press force-up is enabled by defining DIR_LONG_PRESS_EN.
module direction_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned LONG_CYCLES     = 16
) (
   input  logic CLK,
   input  logic reset,
   input  logic btn_in,
   output logic chnge,
   output logic press_pulse,
   output logic long_pulse
);

   typedef enum logic [1:0] {
      StIdle        = 2'd0,
      StPressWait   = 2'd1,
      StPressed     = 2'd2,
      StReleaseWait = 2'd3
   } state_e;

   localparam logic [7:0] DbLast = 8'(DEBOUNCE_CYCLES - 1);

   state_e     state_q;
   logic       s1_q;
   logic       btn_s_q;
   logic [7:0] db_cnt_q;
   logic       chnge_q;
   logic       press_pulse_q;

`ifdef DIR_LONG_PRESS_EN
   localparam logic [7:0] LongLast = 8'(LONG_CYCLES - 1);
   // Parking one past the fire value keeps the long press from re-firing while held.
   localparam logic [7:0] LongSat  = 8'(LONG_CYCLES);

   logic [7:0] hold_cnt_q;
   logic       long_pulse_q;
`endif

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q       <= StIdle;
         s1_q          <= 1'b0;
         btn_s_q       <= 1'b0;
         db_cnt_q      <= 8'd0;
         chnge_q       <= 1'b1;
         press_pulse_q <= 1'b0;
`ifdef DIR_LONG_PRESS_EN
         hold_cnt_q    <= 8'd0;
         long_pulse_q  <= 1'b0;
`endif
      end else begin
         s1_q          <= btn_in;
         btn_s_q       <= s1_q;
         press_pulse_q <= 1'b0;
`ifdef DIR_LONG_PRESS_EN
         long_pulse_q  <= 1'b0;
`endif
         unique case (state_q)
            StIdle: begin
               if (btn_s_q) begin
                  state_q  <= StPressWait;
                  db_cnt_q <= 8'd0;
               end
            end
            StPressWait: begin
               if (!btn_s_q) begin
                  state_q <= StIdle;
               end else if (db_cnt_q == DbLast) begin
                  state_q       <= StPressed;
                  chnge_q       <= ~chnge_q;
                  press_pulse_q <= 1'b1;
`ifdef DIR_LONG_PRESS_EN
                  hold_cnt_q    <= 8'd0;
`endif
               end else begin
                  db_cnt_q <= db_cnt_q + 8'd1;
               end
            end
            StPressed: begin
               if (!btn_s_q) begin
                  state_q  <= StReleaseWait;
                  db_cnt_q <= 8'd0;
`ifdef DIR_LONG_PRESS_EN
               end else if (hold_cnt_q == LongLast) begin
                  chnge_q      <= 1'b1;
                  long_pulse_q <= 1'b1;
                  hold_cnt_q   <= LongSat;
               end else if (hold_cnt_q < LongLast) begin
                  hold_cnt_q <= hold_cnt_q + 8'd1;
`endif
               end
            end
            StReleaseWait: begin
               // Release bounce returns to PRESSED without touching chnge or hold_cnt.
               if (btn_s_q) begin
                  state_q <= StPressed;
               end else if (db_cnt_q == DbLast) begin
                  state_q <= StIdle;
               end else begin
                  db_cnt_q <= db_cnt_q + 8'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign chnge       = chnge_q;
   assign press_pulse = press_pulse_q;
`ifdef DIR_LONG_PRESS_EN
   assign long_pulse  = long_pulse_q;
`else
   assign long_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_direction_ctrl.sv
// Directed bench for direction_ctrl at default parameters; long-press checks follow
// DIR_LONG_PRESS_EN.
module tb_direction_ctrl;

   logic CLK;
   logic reset;
   logic btn_in;
   logic chnge;
   logic press_pulse;
   logic long_pulse;

   int checks = 0;
   int fails  = 0;
   int pp     = 0;
   int lp     = 0;

   direction_ctrl dut (
      .CLK         (CLK),
      .reset       (reset),
      .btn_in      (btn_in),
      .chnge       (chnge),
      .press_pulse (press_pulse),
      .long_pulse  (long_pulse)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // One rising edge, then sample 1 time unit later; pulse counts accumulate here.
   task automatic tick();
      @(posedge CLK);
      #1;
      pp = pp + int'(press_pulse);
      lp = lp + int'(long_pulse);
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // State encoding: 0 IDLE, 1 PRESS_WAIT, 2 PRESSED, 3 RELEASE_WAIT.
   task automatic chk_st(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed state %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      reset  = 1'b1;
      btn_in = 1'b0;
      tick();
      tick();
      chk("rst_chnge", chnge, 1'b1);
      chk("rst_press_pulse", press_pulse, 1'b0);
      chk("rst_long_pulse", long_pulse, 1'b0);
      chk_st("rst_state", dut.state_q, 2'd0);
      reset = 1'b0;
      tick();
      pp = 0;
      lp = 0;

      // Clean press, first time: 1 -> 0 at E6
      btn_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 5) chk("t2a_e5_no_toggle", chnge, 1'b1);
         if (i == 6) begin
            chk("t2a_e6_toggle", chnge, 1'b0);
            chk("t2a_e6_pulse", press_pulse, 1'b1);
         end
         if (i == 7) chk("t2a_e7_pulse_end", press_pulse, 1'b0);
      end
      btn_in = 1'b0;
      repeat (10) tick();
      chk_int("t2a_one_pulse", pp, 1);
      chk("t2a_no_retoggle", chnge, 1'b0);
      chk_st("t2a_idle", dut.state_q, 2'd0);

      // Clean press, second time: 0 -> 1 at E6
      btn_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 5) chk("t2b_e5_no_toggle", chnge, 1'b0);
         if (i == 6) chk("t2b_e6_toggle", chnge, 1'b1);
      end
      btn_in = 1'b0;
      repeat (10) tick();
      chk_int("t2b_two_pulses", pp, 2);
      chk("t2b_chnge", chnge, 1'b1);

      // Bounce reject: 1,1,1,0 x5 never reaches the debounce terminal
      for (int r = 0; r < 5; r++) begin
         for (int k = 0; k < 4; k++) begin
            btn_in = (k < 3);
            tick();
         end
      end
      btn_in = 1'b0;
      repeat (4) tick();
      chk("t3_chnge_kept", chnge, 1'b1);
      chk_int("t3_no_pulse", pp, 2);

      // Release bounce after a confirmed press
      btn_in = 1'b1;
      repeat (8) tick();
      chk("t4_pressed_toggle", chnge, 1'b0);
      for (int i = 0; i < 12; i++) begin
         btn_in = (i == 2 || i == 3);
         tick();
         if (i == 5) chk_st("t4_f5_back_pressed", dut.state_q, 2'd2);
         if (i == 9) chk_st("t4_f9_release_wait", dut.state_q, 2'd3);
         if (i == 10) chk_st("t4_f10_idle", dut.state_q, 2'd0);
      end
      chk("t4_single_toggle", chnge, 1'b0);
      chk_int("t4_single_pulse", pp, 3);

      // Reset in the middle of the press debounce
      btn_in = 1'b1;
      repeat (4) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_rst_chnge", chnge, 1'b1);
      chk("t5_rst_no_pulse", press_pulse, 1'b0);
      chk_st("t5_rst_idle", dut.state_q, 2'd0);
      for (int i = 5; i < 12; i++) begin
         tick();
         if (i == 6) chk("t5_e6_no_toggle", chnge, 1'b1);
         if (i == 10) chk("t5_e10_no_toggle", chnge, 1'b1);
         if (i == 11) begin
            chk("t5_e11_toggle", chnge, 1'b0);
            chk("t5_e11_pulse", press_pulse, 1'b1);
         end
      end
      btn_in = 1'b0;
      repeat (10) tick();
      chk_int("t5_pulse_count", pp, 4);

      // Long press from chnge=1
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("t6_rst_chnge", chnge, 1'b1);
      pp = 0;
      lp = 0;
      btn_in = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (i == 6) chk("t6_e6_toggle", chnge, 1'b0);
         if (i == 21) begin
            chk("t6_e21_chnge", chnge, 1'b0);
            chk("t6_e21_long", long_pulse, 1'b0);
         end
`ifdef DIR_LONG_PRESS_EN
         if (i == 22) begin
            chk("t6_e22_forced", chnge, 1'b1);
            chk("t6_e22_long", long_pulse, 1'b1);
         end
`else
         if (i == 22) begin
            chk("t6_e22_chnge", chnge, 1'b0);
            chk("t6_e22_long", long_pulse, 1'b0);
         end
`endif
         if (i == 23) chk("t6_e23_long_end", long_pulse, 1'b0);
      end
      btn_in = 1'b0;
      repeat (10) tick();
      chk_int("t6_press_pulses", pp, 1);
`ifdef DIR_LONG_PRESS_EN
      chk_int("t6_long_pulses", lp, 1);
      chk("t6_final_chnge", chnge, 1'b1);
`else
      chk_int("t6_long_pulses", lp, 0);
      chk("t6_final_chnge", chnge, 1'b0);
`endif

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
